// File: rtl/adder_pipe.sv
// Pipelined WIDTH-bit add/subtract, one CH-bit chunk per stage, valid/ready on both sides.
// Optional ADDER_SAT_EN: saturate the result to signed max/min on overflow.
module adder_pipe #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_adder_a,
  input  logic [WIDTH-1:0] i_adder_b,
  input  logic             i_sub,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_adder,
  output logic             o_carry,
  output logic             o_overflow
);

  localparam int unsigned CH   = WIDTH / STAGES;
  localparam int unsigned LAST = STAGES - 1;

  logic [STAGES-1:0] valid_q, valid_d;
  logic [STAGES-1:0] carry_q, carry_d;
  logic [STAGES-1:0] sa_q, sa_d;
  logic [STAGES-1:0] sb_q, sb_d;
  logic [WIDTH-1:0]  res_q [STAGES];
  logic [WIDTH-1:0]  res_d [STAGES];
  // Pending operand bits are kept right-justified: the next chunk is always [CH-1:0].
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  a_d [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  b_d [STAGES];
  logic [CH:0]       sum [STAGES];
  logic [WIDTH-1:0]  b_in;
  logic              adv;
  logic              ovf;

  always_comb begin
    adv    = !valid_q[LAST] || i_ready;
    b_in   = i_sub ? ~i_adder_b : i_adder_b;
    sum[0] = {1'b0, i_adder_a[CH-1:0]} + {1'b0, b_in[CH-1:0]} + {{CH{1'b0}}, i_sub};
    for (int unsigned k = 1; k < STAGES; k++) begin
      sum[k] = {1'b0, a_q[k-1][CH-1:0]} + {1'b0, b_q[k-1][CH-1:0]}
             + {{CH{1'b0}}, carry_q[k-1]};
    end
  end

  always_comb begin
    valid_d = valid_q;
    carry_d = carry_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    for (int unsigned k = 0; k < STAGES; k++) begin
      res_d[k] = res_q[k];
      a_d[k]   = a_q[k];
      b_d[k]   = b_q[k];
    end
    if (adv) begin
      valid_d[0]          = i_valid;
      res_d[0]            = '0;
      res_d[0][CH-1:0]    = sum[0][CH-1:0];
      carry_d[0]          = sum[0][CH];
      a_d[0]              = i_adder_a >> CH;
      b_d[0]              = b_in >> CH;
      sa_d[0]             = i_adder_a[WIDTH-1];
      sb_d[0]             = b_in[WIDTH-1];
      for (int unsigned k = 1; k < STAGES; k++) begin
        valid_d[k]          = valid_q[k-1];
        res_d[k]            = res_q[k-1];
        res_d[k][k*CH +: CH] = sum[k][CH-1:0];
        carry_d[k]          = sum[k][CH];
        a_d[k]              = a_q[k-1] >> CH;
        b_d[k]              = b_q[k-1] >> CH;
        sa_d[k]             = sa_q[k-1];
        sb_d[k]             = sb_q[k-1];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      valid_q <= '0;
      carry_q <= '0;
      sa_q    <= '0;
      sb_q    <= '0;
      for (int unsigned k = 0; k < STAGES; k++) begin
        res_q[k] <= '0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
      end
    end else begin
      valid_q <= valid_d;
      carry_q <= carry_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      for (int unsigned k = 0; k < STAGES; k++) begin
        res_q[k] <= res_d[k];
        a_q[k]   <= a_d[k];
        b_q[k]   <= b_d[k];
      end
    end
  end

  always_comb begin
    o_ready    = adv;
    o_valid    = valid_q[LAST];
    o_carry    = carry_q[LAST];
    ovf        = (sa_q[LAST] == sb_q[LAST]) && (res_q[LAST][WIDTH-1] != sa_q[LAST]);
    o_overflow = ovf;
`ifdef ADDER_SAT_EN
    o_adder    = ovf ? {sa_q[LAST], {(WIDTH-1){~sa_q[LAST]}}} : res_q[LAST];
`else
    o_adder    = res_q[LAST];
`endif
  end

endmodule

// File: tb/tb_adder_pipe.sv
// Directed self-checking bench for adder_pipe at WIDTH=32, STAGES=4.
// Honours ADDER_SAT_EN for the expected value of overflowing sums.
module tb_adder_pipe;

  logic        i_clk;
  logic        i_reset;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_adder_a;
  logic [31:0] i_adder_b;
  logic        i_sub;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_adder;
  logic        o_carry;
  logic        o_overflow;

  int checks   = 0;
  int failures = 0;

`ifdef ADDER_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  adder_pipe #(.WIDTH(32), .STAGES(4)) dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_adder_a  (i_adder_a),
    .i_adder_b  (i_adder_b),
    .i_sub      (i_sub),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_adder    (o_adder),
    .o_carry    (o_carry),
    .o_overflow (o_overflow)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // One isolated op: accept, then exact 4-cycle latency, then consumed.
  task automatic send(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic sub, input logic [31:0] exp_s,
                      input logic exp_c, input logic exp_v);
    i_adder_a = a;
    i_adder_b = b;
    i_sub     = sub;
    i_valid   = 1'b1;
    #1;
    chk({tag, "_ready"}, {31'd0, o_ready}, 32'd1);
    step();
    i_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk({tag, "_early"}, {31'd0, o_valid}, 32'd0);
      step();
    end
    chk({tag, "_valid"}, {31'd0, o_valid}, 32'd1);
    chk({tag, "_sum"}, o_adder, exp_s);
    chk({tag, "_carry"}, {31'd0, o_carry}, {31'd0, exp_c});
    chk({tag, "_ovf"}, {31'd0, o_overflow}, {31'd0, exp_v});
    step();
    chk({tag, "_drain"}, {31'd0, o_valid}, 32'd0);
  endtask

  logic [31:0] sa_t [8];
  logic [31:0] sb_t [8];
  logic        ss_t [8];
  logic [31:0] se_t [8];
  int          sent, got, stall_left, cyc;
  bit          stalled, exp_rdy;

  initial begin
    i_reset   = 1'b1;
    i_valid   = 1'b0;
    i_ready   = 1'b1;
    i_adder_a = '0;
    i_adder_b = '0;
    i_sub     = 1'b0;
    step();
    step();
    i_reset = 1'b0;
    #1;
    chk("rst_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_sum",   o_adder, 32'd0);
    chk("rst_carry", {31'd0, o_carry}, 32'd0);
    chk("rst_ovf",   {31'd0, o_overflow}, 32'd0);
    chk("rst_ready", {31'd0, o_ready}, 32'd1);

    send("add_small",  32'h0000_0001, 32'h0000_0002, 1'b0, 32'h0000_0003, 1'b0, 1'b0);
    send("add_ripple", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    send("add_ovf",    32'h7FFF_FFFF, 32'h0000_0001, 1'b0,
         SAT ? 32'h7FFF_FFFF : 32'h8000_0000, 1'b0, 1'b1);
    send("sub_neg",    32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    send("sub_pos",    32'h0000_0007, 32'h0000_0005, 1'b1, 32'h0000_0002, 1'b1, 1'b0);
    send("sub_ovf",    32'h8000_0000, 32'h0000_0001, 1'b1,
         SAT ? 32'h8000_0000 : 32'h7FFF_FFFF, 1'b1, 1'b1);
    send("add_chunk",  32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 1'b0, 1'b0);
    send("add_negovf", 32'h8000_0000, 32'h8000_0000, 1'b0,
         SAT ? 32'h8000_0000 : 32'h0000_0000, 1'b1, 1'b1);

    // Streaming with a 3-cycle output stall at the first result.
    sa_t[0] = 32'h0000_0010; sb_t[0] = 32'h0000_0020; ss_t[0] = 1'b0; se_t[0] = 32'h0000_0030;
    sa_t[1] = 32'h0000_00FF; sb_t[1] = 32'h0000_0001; ss_t[1] = 1'b0; se_t[1] = 32'h0000_0100;
    sa_t[2] = 32'h1234_5678; sb_t[2] = 32'h1111_1111; ss_t[2] = 1'b0; se_t[2] = 32'h2345_6789;
    sa_t[3] = 32'h0001_0000; sb_t[3] = 32'h0000_0001; ss_t[3] = 1'b1; se_t[3] = 32'h0000_FFFF;
    sa_t[4] = 32'hFFFF_FFFF; sb_t[4] = 32'hFFFF_FFFF; ss_t[4] = 1'b0; se_t[4] = 32'hFFFF_FFFE;
    sa_t[5] = 32'h0000_000A; sb_t[5] = 32'h0000_000A; ss_t[5] = 1'b1; se_t[5] = 32'h0000_0000;
    sa_t[6] = 32'h4000_0000; sb_t[6] = 32'h3FFF_FFFF; ss_t[6] = 1'b0; se_t[6] = 32'h7FFF_FFFF;
    sa_t[7] = 32'hDEAD_BEEF; sb_t[7] = 32'h0000_BEEF; ss_t[7] = 1'b1; se_t[7] = 32'hDEAD_0000;
    sent = 0; got = 0; stall_left = 0; cyc = 0; stalled = 1'b0;
    while (got < 8 && cyc < 60) begin
      if (o_valid && !stalled) begin
        stalled    = 1'b1;
        stall_left = 3;
      end
      exp_rdy = (stall_left == 0);
      i_ready = exp_rdy;
      if (sent < 8) begin
        i_adder_a = sa_t[sent];
        i_adder_b = sb_t[sent];
        i_sub     = ss_t[sent];
        i_valid   = 1'b1;
      end else begin
        i_valid = 1'b0;
      end
      #1;
      chk("stream_ready", {31'd0, o_ready}, {31'd0, exp_rdy});
      if (stall_left > 0) begin
        chk("stall_valid", {31'd0, o_valid}, 32'd1);
        chk("stall_hold",  o_adder, se_t[got]);
        stall_left--;
      end else if (o_valid) begin
        chk("stream_sum", o_adder, se_t[got]);
        got++;
      end
      if (i_valid && o_ready) sent++;
      step();
      cyc++;
    end
    chk("stream_got",  got, 32'd8);
    chk("stream_sent", sent, 32'd8);
    chk("stream_cyc",  cyc, 32'd15);
    i_valid = 1'b0;
    i_ready = 1'b1;
    chk("stream_empty", {31'd0, o_valid}, 32'd0);

    // Reset with three ops in flight: nothing may emerge afterwards.
    for (int i = 0; i < 3; i++) begin
      i_adder_a = 32'h0000_0100 + i;
      i_adder_b = 32'h0000_0001;
      i_sub     = 1'b0;
      i_valid   = 1'b1;
      step();
    end
    i_valid = 1'b0;
    i_reset = 1'b1;
    step();
    i_reset = 1'b0;
    chk("mid_rst_valid", {31'd0, o_valid}, 32'd0);
    chk("mid_rst_sum",   o_adder, 32'd0);
    chk("mid_rst_ready", {31'd0, o_ready}, 32'd1);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("mid_rst_quiet", {31'd0, o_valid}, 32'd0);
    end
    send("post_rst", 32'h0000_1234, 32'h0000_4321, 1'b0, 32'h0000_5555, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
